// File: rtl/w5300_pkg.sv
// w5300_pkg: shared state encoding, bus direction bits and widths for the W5300 arbiter
package w5300_pkg;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;
endpackage

// File: rtl/w5300_rr_pick.sv
// w5300_rr_pick: two-port round-robin chooser where an active lock owner with a pending request wins
module w5300_rr_pick (
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  input  logic lock_vld,
  input  logic lock_port,
  output logic grant,
  output logic sel
);
  always_comb begin
    grant = v0 | v1;
    sel = (lock_vld && (lock_port ? v1 : v0)) ? lock_port : (v0 && v1) ? ptr : v1;
  end
endmodule

// File: rtl/w5300_bus_arbiter.sv
// w5300_bus_arbiter: two-port round-robin W5300 bus arbiter with burst lock; W5300_ARB_TIMEOUT_EN adds an access timeout
module w5300_bus_arbiter
  import w5300_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_wr,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_lock,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_wr,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_lock,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          bus_start,
  output logic [AW:0]   bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ready
);
  state_t state, state_nx;
  logic grant, sel, accept, done, tmo, timeout;
  logic ptr, owner, lock_r, lock_vld, lock_port;
  w5300_rr_pick u_pick (
    .v0(req0_valid),
    .v1(req1_valid),
    .ptr(ptr),
    .lock_vld(lock_vld),
    .lock_port(lock_port),
    .grant(grant),
    .sel(sel)
  );
  assign done = state == WAIT_DONE && bus_ready;
  assign timeout = tmo && !done;
`ifdef W5300_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  logic err, waiting;
  assign waiting = state == WAIT_ACK || state == WAIT_DONE;
  assign tmo = waiting && cnt == TMAX;
  assign rsp_err = state == RESP && err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= waiting ? cnt + 1'b1 : '0;
      err <= state_nx == RESP ? timeout : err;
    end
`else
  logic unused_tc;
  assign unused_tc = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = grant ? ISSUE : IDLE;
      ISSUE:     state_nx = bus_ready ? WAIT_ACK : ISSUE;
      WAIT_ACK:  state_nx = timeout ? RESP : !bus_ready ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: state_nx = (done || timeout) ? RESP : WAIT_DONE;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    accept = !rst && state == IDLE && grant;
    req0_ready = accept && !sel;
    req1_ready = accept && sel;
    bus_start = state == ISSUE && bus_ready;
    rsp0_valid = state == RESP && !owner;
    rsp1_valid = state == RESP && owner;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      owner <= 1'b0;
      lock_r <= 1'b0;
      lock_vld <= 1'b0;
      lock_port <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= sel;
        lock_r <= sel ? req1_lock : req0_lock;
        bus_addr <= sel ? {req1_wr ? WR : RD, req1_addr} : {req0_wr ? WR : RD, req0_addr};
        bus_wdata <= sel ? req1_wdata : req0_wdata;
        lock_vld <= lock_vld && sel == lock_port;
      end
      if (timeout) lock_r <= 1'b0;
      if ((done && bus_addr[AW] == RD) || timeout) rsp_rdata <= timeout ? '0 : bus_rdata;
      if (state == RESP) begin
        ptr <= ~owner;
        lock_vld <= lock_r;
        lock_port <= owner;
      end
    end
endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// tb_w5300_bus_arbiter: scoreboard bench with requester drivers and a W5300 engine model
module tb_w5300_bus_arbiter;
  typedef struct {
    logic [9:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic        lock;
    logic        tmo;
  } req_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid, req0_wr, req0_lock, req0_ready;
  logic req1_valid, req1_wr, req1_lock, req1_ready;
  logic [9:0] req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic rsp0_valid, rsp1_valid, rsp_err, bus_start, bus_ready;
  logic [15:0] rsp_rdata, bus_wdata, bus_rdata;
  logic [10:0] bus_addr;
  int n_vec = 0, n_err = 0, cyc = 0, n_starts = 0, n_rsp = 0, n_grants = 0;
  int t_acc = 0, t_start = 0, t_rsp = 0;
  int done_dly = 4;
  logic eng_never = 1'b0;
  req_t pend0[$], pend1[$], exp0[$], exp1[$];
  int grant_log[$];
  req_t cur;
  logic busy = 1'b0, cur_port = 1'b0, acc0, acc1;
  logic [15:0] last_rd = '0, exp_rd;
  w5300_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .bus_start(bus_start), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );
  function automatic logic [15:0] eng_val(input logic [9:0] a);
    return 16'h5300 ^ {6'h0, a ^ 10'h0FE};
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus_ready = 1'b1;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_start && !eng_never && !rst) begin
        @(posedge clk);
        #1 bus_ready = 1'b0;
        repeat (done_dly) @(posedge clk);
        #1 bus_rdata = eng_val(bus_addr[9:0]);
        bus_ready = 1'b1;
      end
    end
  end
  initial begin
    req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0; req0_lock = 0;
    forever begin
      @(negedge clk);
      acc0 = req0_ready;
      @(posedge clk);
      #1;
      if (acc0 && pend0.size() > 0) pend0.delete(0);
      req0_valid = pend0.size() > 0 && !rst;
      if (pend0.size() > 0) begin
        req0_wr = pend0[0].wr; req0_addr = pend0[0].addr;
        req0_wdata = pend0[0].wdata; req0_lock = pend0[0].lock;
      end
    end
  end
  initial begin
    req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0; req1_lock = 0;
    forever begin
      @(negedge clk);
      acc1 = req1_ready;
      @(posedge clk);
      #1;
      if (acc1 && pend1.size() > 0) pend1.delete(0);
      req1_valid = pend1.size() > 0 && !rst;
      if (pend1.size() > 0) begin
        req1_wr = pend1[0].wr; req1_addr = pend1[0].addr;
        req1_wdata = pend1[0].wdata; req1_lock = pend1[0].lock;
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      if (rsp0_valid || rsp1_valid) n_rsp++;
    end else begin
      if (req0_ready || req1_ready) begin
        n_vec++;
        if ((req0_ready && (req1_ready || !req0_valid)) || (req1_ready && !req1_valid) || busy) begin
          n_err++;
          $display("FAIL accept_legal: ready0=%b ready1=%b valid0=%b valid1=%b busy=%b, need one ready on a valid idle port",
                   req0_ready, req1_ready, req0_valid, req1_valid, busy);
        end else if (req1_ready ? exp1.size() == 0 : exp0.size() == 0) begin
          n_err++;
          $display("FAIL accept_expected: port %0d accepted with no queued request", req1_ready);
        end else begin
          cur_port = req1_ready;
          cur = req1_ready ? exp1.pop_front() : exp0.pop_front();
          busy = 1'b1;
          grant_log.push_back(int'(req1_ready));
          n_grants++;
          t_acc = cyc;
        end
      end
      if (bus_start) begin
        n_vec++;
        n_starts++;
        t_start = cyc;
        if (!busy || !bus_ready || bus_addr !== {~cur.wr, cur.addr} || (cur.wr && bus_wdata !== cur.wdata)) begin
          n_err++;
          $display("FAIL bus_start: addr=%h wdata=%h ready=%b busy=%b, need addr=%h wdata=%h ready=1 busy=1",
                   bus_addr, bus_wdata, bus_ready, busy, {~cur.wr, cur.addr}, cur.wdata);
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        n_vec++;
        n_rsp++;
        t_rsp = cyc;
        exp_rd = cur.tmo ? 16'h0 : cur.wr ? last_rd : eng_val(cur.addr);
        if (!busy || (rsp0_valid && rsp1_valid) || rsp1_valid !== cur_port || rsp_rdata !== exp_rd || rsp_err !== cur.tmo) begin
          n_err++;
          $display("FAIL response: rsp0=%b rsp1=%b rdata=%h err=%b busy=%b, need port %0d rdata=%h err=%b",
                   rsp0_valid, rsp1_valid, rsp_rdata, rsp_err, busy, cur_port, exp_rd, cur.tmo);
        end
        last_rd = exp_rd;
        busy = 1'b0;
      end
    end
  end
  task automatic push(input logic port, input logic [9:0] addr, input logic wr,
                      input logic [15:0] wdata, input logic lock, input logic tmo);
    req_t r;
    r.addr = addr; r.wr = wr; r.wdata = wdata; r.lock = lock; r.tmo = tmo;
    if (port) begin pend1.push_back(r); exp1.push_back(r); end
    else begin pend0.push_back(r); exp0.push_back(r); end
  endtask
  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (pend0.size() == 0 && pend1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    busy = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, bus_start, rsp_rdata, bus_addr, bus_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: outputs=%h, need all zero",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, bus_start, rsp_rdata, bus_addr, bus_wdata});
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({rsp_rdata, bus_addr, bus_wdata} !== '0 || {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, bus_start} !== '0) begin
      n_err++;
      $display("FAIL reset_release: rdata=%h addr=%h wdata=%h strobes=%b, need all zero",
               rsp_rdata, bus_addr, bus_wdata, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, bus_start});
    end
  endtask
  task automatic test_read_timing();
    bit ok;
    done_dly = 4;
    push(1'b0, 10'h0FE, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle(60, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL read_done: transaction did not complete within 60 cycles"); end
    n_vec++;
    if (t_start - t_acc !== 1) begin n_err++; $display("FAIL start_latency: %0d cycles, need 1", t_start - t_acc); end
    n_vec++;
    if (t_rsp - t_acc !== 7) begin n_err++; $display("FAIL rsp_latency: %0d cycles, need 7", t_rsp - t_acc); end
    n_vec++;
    if (rsp_rdata !== 16'h5300) begin n_err++; $display("FAIL rdata_hold: got %h, need 5300", rsp_rdata); end
    n_vec++;
    if (bus_addr !== 11'h4FE) begin n_err++; $display("FAIL bus_addr_read: got %h, need 4fe", bus_addr); end
  endtask
  task automatic test_round_robin();
    bit ok;
    int exp_log[5] = '{0, 1, 0, 1, 0};
    do_reset();
    grant_log.delete();
    @(negedge clk);
    push(1'b0, 10'h012, 1'b0, 16'h0, 1'b0, 1'b0);
    push(1'b0, 10'h3FF, 1'b1, 16'hA5A5, 1'b0, 1'b0);
    push(1'b1, 10'h200, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle(200, ok);
    push(1'b0, 10'h044, 1'b1, 16'h1234, 1'b0, 1'b0);
    push(1'b1, 10'h155, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle(200, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rr_done: requests did not complete"); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ((i < grant_log.size() ? grant_log[i] : -1) !== exp_log[i]) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got port %0d, need port %0d", i, i < grant_log.size() ? grant_log[i] : -1, exp_log[i]);
      end
    end
  endtask
  task automatic test_lock();
    bit ok;
    int exp_log[7] = '{1, 1, 1, 0, 0, 1, 0};
    grant_log.delete();
    push(1'b1, 10'h100, 1'b1, 16'h1111, 1'b1, 1'b0);
    push(1'b1, 10'h101, 1'b1, 16'h2222, 1'b1, 1'b0);
    push(1'b1, 10'h102, 1'b1, 16'h3333, 1'b0, 1'b0);
    push(1'b0, 10'h010, 1'b0, 16'h0, 1'b0, 1'b0);
    push(1'b0, 10'h011, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle(300, ok);
    push(1'b1, 10'h103, 1'b1, 16'h4444, 1'b1, 1'b0);
    wait_idle(100, ok);
    push(1'b0, 10'h020, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle(100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL lock_done: locked owner idle starved the other port"); end
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if ((i < grant_log.size() ? grant_log[i] : -1) !== exp_log[i]) begin
        n_err++;
        $display("FAIL lock_order[%0d]: got port %0d, need port %0d", i, i < grant_log.size() ? grant_log[i] : -1, exp_log[i]);
      end
    end
  endtask
  task automatic test_busy_engine();
    bit ok;
    int s0, g0;
    s0 = n_starts;
    g0 = n_grants;
    @(posedge clk);
    #2 bus_ready = 1'b0;
    push(1'b0, 10'h0AA, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    n_vec++;
    if (n_grants !== g0 + 1) begin n_err++; $display("FAIL busy_accept: %0d grants, need %0d", n_grants - g0, 1); end
    n_vec++;
    if (n_starts !== s0) begin n_err++; $display("FAIL busy_defer: %0d starts while engine busy, need 0", n_starts - s0); end
    @(posedge clk);
    #2 bus_ready = 1'b1;
    wait_idle(60, ok);
    n_vec++;
    if (!ok || n_starts !== s0 + 1) begin
      n_err++;
      $display("FAIL busy_single_start: done=%b starts=%0d, need done=1 starts=1", ok, n_starts - s0);
    end
  endtask
`ifdef W5300_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    eng_never = 1'b1;
    push(1'b0, 10'h0C3, 1'b0, 16'h0, 1'b0, 1'b1);
    wait_idle(60, ok);
    n_vec++;
    if (!ok || t_rsp - t_start !== 9) begin
      n_err++;
      $display("FAIL timeout_latency: done=%b start_to_rsp=%0d, need done=1 and 9", ok, t_rsp - t_start);
    end
    eng_never = 1'b0;
    push(1'b1, 10'h1C3, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle(60, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL timeout_recover: next request did not complete"); end
  endtask
`endif
  task automatic test_reset_mid();
    bit ok;
    int s0, r0;
    done_dly = 10;
    s0 = n_starts;
    push(1'b0, 10'h2AB, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && n_starts == s0; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    busy = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    last_rd = '0;
    r0 = n_rsp;
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, bus_start, rsp_rdata, bus_addr, bus_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: outputs=%h, need all zero",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, bus_start, rsp_rdata, bus_addr, bus_wdata});
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    done_dly = 4;
    push(1'b0, 10'h0FE, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle(80, ok);
    n_vec++;
    if (!ok || n_rsp !== r0 + 1) begin
      n_err++;
      $display("FAIL reset_mid_recover: done=%b responses=%0d, need done=1 responses=1", ok, n_rsp - r0);
    end
  endtask
  initial begin
    test_reset();
    test_read_timing();
    test_round_robin();
    test_lock();
    test_busy_engine();
`ifdef W5300_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
